// File: rtl/axi_cmd_sequencer.sv
// Command sequencer for an AXI4 master: queues incoming read/write commands and
// launches them one at a time, waiting for completion or a timeout before the next.
module axi_cmd_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  m_clk,
  input  logic                  m_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [3:0]            cmd_strb,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [7:0]            cmd_len,
  output logic                  start_write,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [DATA_WIDTH-1:0] m_w_data,
  output logic [3:0]            m_w_strb,
  output logic [ID_WIDTH-1:0]   m_id,
  output logic [7:0]            m_len,
  input  logic                  op_done,
  input  logic                  clear_err,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [15:0]           done_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH + 4 + ID_WIDTH + 8;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       state;
  logic [TMR_W-1:0] wait_cnt;

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             timeout_hit;

  logic                  h_rw;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_data;
  logic [3:0]            h_strb;
  logic [ID_WIDTH-1:0]   h_id;
  logic [7:0]            h_len;

  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign fifo_empty = (fifo_cnt == '0);
  // Ready looks only at occupancy, so a pop in the same cycle never opens a slot early.
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign busy       = (state != S_IDLE) || !fifo_empty;

  assign {h_rw, h_addr, h_data, h_strb, h_id, h_len} = fifo_mem[rd_ptr];

  // op_done wins over a coincident timeout.
  assign timeout_hit = (state == S_WAIT) && !op_done && (wait_cnt == TMR_LAST);

  // Queue storage carries no reset; only pointers and occupancy define its contents.
  always_ff @(posedge m_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_data, cmd_strb, cmd_id, cmd_len};
    end
  end

  always_ff @(posedge m_clk or posedge m_rst) begin
    if (m_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Launch stage: the pop edge registers the head entry and raises the start pulse,
  // so both are visible during the single ISSUE cycle.
  always_ff @(posedge m_clk or posedge m_rst) begin
    if (m_rst) begin
      state       <= S_IDLE;
      start_write <= 1'b0;
      start_read  <= 1'b0;
      wait_cnt    <= '0;
      done_cnt    <= '0;
    end else begin
      start_write <= 1'b0;
      start_read  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state       <= S_ISSUE;
            start_write <= h_rw;
            start_read  <= !h_rw;
          end
        end
        S_ISSUE: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (op_done) begin
            state    <= S_IDLE;
            done_cnt <= done_cnt + 16'd1;
          end else if (wait_cnt == TMR_LAST) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TMR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge m_clk or posedge m_rst) begin
    if (m_rst) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
    end else if (clear_err) begin
      timeout_err <= 1'b0;
    end
  end

  always_ff @(posedge m_clk or posedge m_rst) begin
    if (m_rst) begin
      m_address <= '0;
      m_w_data  <= '0;
      m_w_strb  <= '0;
      m_id      <= '0;
      m_len     <= '0;
    end else if (pop) begin
      m_address <= h_addr;
      m_w_data  <= h_data;
      m_w_strb  <= h_strb;
      m_id      <= h_id;
      m_len     <= h_len;
    end
  end

  a_start_excl: assert property (@(posedge m_clk) disable iff (m_rst)
    !(start_write && start_read));

  a_start_pulse: assert property (@(posedge m_clk) disable iff (m_rst)
    (start_write || start_read) |=> !(start_write || start_read));

endmodule
